shift_add_mult: RTL and testbench
=================================

Name: shift_add_mult

Overview:
- Sequential N x N unsigned multiplier built on a shift-and-add loop.
- Each iteration drives one N-bit ripple adder stage with the running partial-product high half and the multiplicand, then consumes its sum and carry.
- Sits upstream of the N-bit adder and turns it into a multi-cycle arithmetic unit with a start/done handshake.
- Feeds result registers or display logic downstream.

Parameters:
- N, 4, operand width in bits; product width is 2N; legal range 2..16.
- CW, $clog2(N), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  N  multiplicand; captured when start is accepted.
- B  input  N  multiplier; captured when start is accepted.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse; P is valid in this cycle.
- P  output  2N  product; holds its value until the next DONE.

Behaviour:
- One clock is used. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, P=0, internal mcand/acc/count=0.
- States:
  - IDLE: waits for start.
  - RUN: N iterations.
  - DONE: one cycle, then returns to IDLE.
- IDLE -> RUN when start=1 at a clock edge:
  - mcand<=A.
  - acc<={N'b0, B} (2N bits).
  - count<=0.
- RUN, each cycle:
  - Adder inputs: acc[2N-1:N] and (acc[0] ? mcand : 0), Cin=0.
  - Adder outputs: sum[N-1:0], cout.
  - acc <= {cout, sum, acc[N-1:1]}, i.e. (N+1)-bit sum concatenated with the low half, shifted right by 1.
  - count<=count+1.
- RUN -> DONE at the edge where count==N-1. That edge also applies the final iteration and loads P with the resulting acc.
- DONE -> IDLE unconditionally after one cycle.
- Latency: start sampled at edge 0; busy=1 for cycles 1..N; done=1 and P valid in cycle N+1; IDLE from cycle N+2. For N=4, done is 5 cycles after start.
- busy is high exactly in RUN. done is high exactly in DONE. Both are decoded from state with no extra registers.
- start in RUN or DONE is ignored. No queuing; the operation in flight is unaffected.
- A and B may change freely after the accept edge.
- The earliest back-to-back operation is start asserted in the IDLE cycle following DONE. Max throughput is one product per N+2 cycles.
- P updates only on the RUN->DONE edge and retains its value through IDLE and the following RUN.
- Width rule: the adder carry is never dropped; the product is exact for all operands (max (2^N-1)^2 fits in 2N bits).
- Zero operands need no special case; the loop always runs the full N iterations.
- rst_n asserted mid-operation: immediate return to reset values. P is cleared, done is not pulsed, and the partial result is discarded.
- rst_n deassertion is assumed synchronised externally. The first accepted start is at the first edge with rst_n=1.

Decomposition:
- Shared package mult_pkg:
  - State enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default width constant MULT_N=4.
- Sub-module add_nbit (parameter N): combinational N-bit ripple adder with inputs A, B, Cin and outputs Z, Cout, built from single-bit full-adder cells.
- shift_add_mult instantiates exactly one add_nbit. The FSM, counter and shift register stay in the top.

Test Plan:
- Reset, then start with A=15, B=15 -> busy high cycles 1-4; done=1 in cycle 5 with P=225 (8'hE1); busy=0, done=0 in cycle 6; P stays 225.
- A=0, B=13 and A=9, B=0 -> P=0 with done at cycle 5 in both cases. A=1, B=9 -> P=9. A=12, B=10 -> P=120.
- Start with A=3, B=5, then hold start=1 with A=15, B=15 through RUN and DONE -> first done gives P=15. Second operation is accepted in the next IDLE cycle; done 5 cycles later with P=225.
- Start A=7, B=6, then pulse rst_n low in cycle 2 -> busy, done and P go 0 immediately; no done pulse follows. A new start A=7, B=6 after release -> P=42.
- Change A and B every cycle during RUN after start A=11, B=13 -> P=143, unaffected by the changes.
- Exhaustive sweep, all 256 (A,B) pairs back-to-back at max throughput -> P==A*B at every done pulse; done never asserts outside DONE; busy and done are never high together.

Source files
------------

// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier slice.
//   state_t : FSM encoding (IDLE / RUN / DONE)
//   MULT_N  : default operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MULT_N = 4;

endpackage

// File: rtl/shift_add_mult_if.sv
// Handshake/operand bundle for shift_add_mult.
//   start : request from the requester, sampled by the unit only in IDLE
//   A, B  : N-bit multiplicand / multiplier
//   busy  : unit is iterating
//   done  : one-cycle pulse, P valid
//   P     : 2N-bit product, held until the next done
// master = requester side, slave = multiplier side.
interface shift_add_mult_if
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) ();

  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*N-1:0] P;

  modport master (
    output start, A, B,
    input  busy, done, P
  );

  modport slave (
    input  start, A, B,
    output busy, done, P
  );

endinterface

// File: rtl/shift_add_mult_add_nbit.sv
// Combinational N-bit ripple-carry adder built from single-bit full adders.
//   A, B : N-bit addends
//   Cin  : carry in
//   Z    : N-bit sum
//   Cout : carry out of the top bit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module add_nbit
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Z,
  output logic         Cout
);

  // carry[i] feeds bit i; carry[N] is the final carry out
  logic [N:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (Z[i]),
      .co (carry[i+1])
    );
  end

  assign Cout = carry[N];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential N x N unsigned multiplier using a shift-and-add loop around a
// single N-bit ripple adder. One operation takes N RUN cycles followed by a
// one-cycle DONE pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of shift_add_mult_if (start, A, B, busy, done, P)
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_add_mult_if.slave   bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t         state, state_nxt;
  logic [N-1:0]   mcand;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  count;
  logic [2*N-1:0] p_q;

  logic [N-1:0]   add_b;
  logic [N-1:0]   sum;
  logic           cout;
  logic [2*N-1:0] acc_nxt;
  logic           last_iter;

  // Multiplier bit for this iteration sits in acc[0]; it gates the multiplicand.
  assign add_b = acc[0] ? mcand : '0;

  add_nbit #(.N(N)) u_add (
    .A    (acc[2*N-1:N]),
    .B    (add_b),
    .Cin  (1'b0),
    .Z    (sum),
    .Cout (cout)
  );

  // Keep the carry: the (N+1)-bit sum drops into the top while the whole
  // accumulator shifts right by one.
  assign acc_nxt   = {cout, sum, acc[N-1:1]};
  assign last_iter = (count == CW'(N - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      count <= '0;
      p_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.A;
            acc   <= {{N{1'b0}}, bus.B};
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          count <= count + CW'(1);
          if (last_iter) p_q <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.P    = p_q;

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   overlap_cnt;
  int   double_done_cnt;
  logic prev_done;

  shift_add_mult_if #(.N(N)) bus ();

  shift_add_mult #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol watchers sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy && bus.done) overlap_cnt++;
      if (bus.done && prev_done) double_done_cnt++;
      prev_done <= bus.done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE; returns product and cycles from accept to done.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [2*N-1:0] p, output int lat);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    p = bus.P;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b P=%0d, want 0 0 0", bus.busy, bus.done, bus.P);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_max_operands();
    bus.start = 1'b1;
    bus.A     = 4'd15;
    bus.B     = 4'd15;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tests++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        fails++;
        $display("FAIL run_cycle%0d: busy=%b done=%b, want 1 0", c, bus.busy, bus.done);
      end
      tick();
    end
    tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.P !== 8'hE1) begin
      fails++;
      $display("FAIL done_cycle5: done=%b busy=%b P=%0d, want 1 0 225", bus.done, bus.busy, bus.P);
    end
    tick();
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.P !== 8'hE1) begin
      fails++;
      $display("FAIL idle_cycle6: done=%b busy=%b P=%0d, want 0 0 225", bus.done, bus.busy, bus.P);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0]   av [4] = '{4'd0, 4'd9, 4'd1, 4'd12};
    logic [N-1:0]   bv [4] = '{4'd13, 4'd0, 4'd9, 4'd10};
    logic [2*N-1:0] ev [4] = '{8'd0, 8'd0, 8'd9, 8'd120};
    logic [2*N-1:0] p;
    int             lat;
    for (int i = 0; i < 4; i++) begin
      do_op(av[i], bv[i], p, lat);
      tests++;
      if (lat != 5 || p !== ev[i]) begin
        fails++;
        $display("FAIL directed_%0dx%0d: P=%0d lat=%0d, want P=%0d lat=5", av[i], bv[i], p, lat, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_start_held();
    logic [2*N-1:0] p;
    int             lat;
    bus.start = 1'b1;
    bus.A     = 4'd3;
    bus.B     = 4'd5;
    tick();
    bus.A = 4'd15;
    bus.B = 4'd15;
    lat = 1;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if (lat != 5 || bus.P !== 8'd15) begin
      fails++;
      $display("FAIL held_first: P=%0d lat=%0d, want P=15 lat=5", bus.P, lat);
    end
    tick();
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== 8'd15) begin
      fails++;
      $display("FAIL held_idle: busy=%b done=%b P=%0d, want 0 0 15", bus.busy, bus.done, bus.P);
    end
    tick();
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.P !== 8'd15) begin
      fails++;
      $display("FAIL held_second_accept: busy=%b P=%0d, want 1 15", bus.busy, bus.P);
    end
    lat = 1;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    p = bus.P;
    tests++;
    if (lat != 5 || p !== 8'd225) begin
      fails++;
      $display("FAIL held_second: P=%0d lat=%0d, want P=225 lat=5", p, lat);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic [2*N-1:0] p;
    int             lat;
    int             done_seen;
    bus.start = 1'b1;
    bus.A     = 4'd7;
    bus.B     = 4'd6;
    tick();
    bus.start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.P !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_op: busy=%b done=%b P=%0d, want 0 0 0", bus.busy, bus.done, bus.P);
    end
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.done) done_seen++;
    end
    tests++;
    if (done_seen != 0) begin
      fails++;
      $display("FAIL no_done_after_reset: pulses=%0d, want 0", done_seen);
    end
    do_op(4'd7, 4'd6, p, lat);
    tests++;
    if (lat != 5 || p !== 8'd42) begin
      fails++;
      $display("FAIL after_reset_op: P=%0d lat=%0d, want P=42 lat=5", p, lat);
    end
    tick();
  endtask

  task automatic test_operand_change();
    int lat;
    bus.start = 1'b1;
    bus.A     = 4'd11;
    bus.B     = 4'd13;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      bus.A = 4'(lat * 5 + 2);
      bus.B = 4'(lat * 3 + 1);
      tick();
      lat++;
    end
    tests++;
    if (lat != 5 || bus.P !== 8'd143) begin
      fails++;
      $display("FAIL operand_change: P=%0d lat=%0d, want P=143 lat=5", bus.P, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back_sweep();
    logic [2*N-1:0] p;
    logic [2*N-1:0] exp_p;
    int             lat;
    overlap_cnt     = 0;
    double_done_cnt = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(4'(a), 4'(b), p, lat);
        exp_p = 8'(a * b);
        tests++;
        if (lat != 5 || p !== exp_p) begin
          fails++;
          $display("FAIL sweep_%0dx%0d: P=%0d lat=%0d, want P=%0d lat=5", a, b, p, lat, exp_p);
        end
        tick();
        tests++;
        if (bus.done !== 1'b0 || bus.P !== exp_p) begin
          fails++;
          $display("FAIL sweep_hold_%0dx%0d: done=%b P=%0d, want 0 %0d", a, b, bus.done, bus.P, exp_p);
        end
      end
    end
    tests++;
    if (overlap_cnt != 0 || double_done_cnt != 0) begin
      fails++;
      $display("FAIL sweep_protocol: overlap=%0d double_done=%0d, want 0 0", overlap_cnt, double_done_cnt);
    end
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    overlap_cnt     = 0;
    double_done_cnt = 0;
    prev_done       = 1'b0;
    test_reset();
    test_max_operands();
    test_directed();
    test_start_held();
    test_reset_mid_op();
    test_operand_change();
    test_back_to_back_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
